// File: rtl/lowrisc_hwrng_reader.sv
// Consumer front end for the hardware RNG entropy FIFO: strobed reads, a one-word holding
// register, a repetition-count health test and a single-cycle-ack register bus.
// Define HWRNG_READER_IRQ_EN to add the irq_o output.
module lowrisc_hwrng_reader #(
    parameter int unsigned READ_LAT  = 4,
    parameter int unsigned REP_LIMIT = 3
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    output logic        rdfifo_o,
    input  logic [31:0] fifo_out_i,
    input  logic        fifo_empty_i,
    input  logic        fifo_rderr_i,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [1:0]  addr_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] rdata_o,
`ifdef HWRNG_READER_IRQ_EN
    output logic        irq_o,
`endif
    output logic        ack_o
);

    typedef enum logic [3:0] {
        ST_IDLE    = 4'd0,
        ST_PULSE   = 4'd1,
        ST_WAIT    = 4'd2,
        ST_CAPTURE = 4'd3
    } state_e;

    localparam logic [3:0] WaitInit = 4'(READ_LAT - 2);
    localparam logic [3:0] RepLimit = 4'(REP_LIMIT);

    state_e      state_q;
    logic [3:0]  wait_cnt_q;
    logic        rdfifo_q;
    logic        valid_q, valid_d;
    logic [31:0] hold_q, hold_d;
    logic        en_q, en_d;
    logic        irq_en_q, irq_en_d;
    logic        fail_q, fail_d;
    logic        rderr_q, rderr_d;
    logic        under_q, under_d;
    logic [3:0]  rep_cnt_q, rep_cnt_d;
    logic [31:0] prev_q, prev_d;
    logic        prev_valid_q, prev_valid_d;
    logic [31:0] count_q, count_d;
    logic [31:0] rdata_q, rdata_d;
    logic        ack_q;

    logic        start_s, capture_s, rd_s, wr_ctrl_s, clear_s;
    logic [3:0]  rep_next_s;
    logic [31:0] status_s;
    logic        unused_wdata_s;

    assign capture_s = (state_q == ST_CAPTURE);
    assign start_s   = en_q & ~valid_q & ~fifo_empty_i & ~fail_q;
    assign rd_s      = req_i & ~we_i;
    assign wr_ctrl_s = req_i & we_i & (addr_i == 2'd2);
    assign clear_s   = wr_ctrl_s & wdata_i[2];
    assign status_s  = {16'd0, state_q, rep_cnt_q, 3'd0, under_q, rderr_q, fail_q,
                        fifo_empty_i, valid_q};
    assign unused_wdata_s = ^wdata_i[31:3];

    // Repetition count the word on fifo_out_i would produce if captured now
    always_comb begin
        rep_next_s = 4'd1;
        if (prev_valid_q && (fifo_out_i == prev_q)) begin
            rep_next_s = (rep_cnt_q == 4'hF) ? 4'hF : rep_cnt_q + 4'd1;
        end else begin
            rep_next_s = 4'd1;
        end
    end

    // Read-strobe sequencer: one strobe cycle, then READ_LAT-1 wait cycles, then capture
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ST_IDLE;
            wait_cnt_q <= 4'd0;
            rdfifo_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_s) begin
                        state_q  <= ST_PULSE;
                        rdfifo_q <= 1'b1;
                    end else begin
                        rdfifo_q <= 1'b0;
                    end
                end
                ST_PULSE: begin
                    state_q    <= ST_WAIT;
                    wait_cnt_q <= WaitInit;
                    rdfifo_q   <= 1'b0;
                end
                ST_WAIT: begin
                    rdfifo_q <= 1'b0;
                    if (wait_cnt_q == 4'd0) begin
                        state_q <= ST_CAPTURE;
                    end else begin
                        wait_cnt_q <= wait_cnt_q - 4'd1;
                    end
                end
                ST_CAPTURE: begin
                    state_q  <= ST_IDLE;
                    rdfifo_q <= 1'b0;
                end
                default: begin
                    state_q  <= ST_IDLE;
                    rdfifo_q <= 1'b0;
                end
            endcase
        end
    end

    // Bus decode, holding register and health test; a capture overrides a same-cycle DATA read
    always_comb begin
        valid_d      = valid_q;
        hold_d       = hold_q;
        en_d         = en_q;
        irq_en_d     = irq_en_q;
        fail_d       = fail_q;
        under_d      = under_q;
        rep_cnt_d    = rep_cnt_q;
        prev_d       = prev_q;
        prev_valid_d = prev_valid_q;
        count_d      = count_q;
        rdata_d      = 32'd0;

        if (rd_s) begin
            case (addr_i)
                2'd0: begin
                    if (valid_q && !fail_q) begin
                        rdata_d = hold_q;
                        valid_d = 1'b0;
                        count_d = count_q + 32'd1;
                    end else begin
                        under_d = 1'b1;
                    end
                end
                2'd1:    rdata_d = status_s;
                2'd2:    rdata_d = {30'd0, irq_en_q, en_q};
                2'd3:    rdata_d = count_q;
                default: rdata_d = 32'd0;
            endcase
        end else if (wr_ctrl_s) begin
            en_d     = wdata_i[0];
            irq_en_d = wdata_i[1];
        end else begin
            rdata_d = 32'd0;
        end

        if (capture_s) begin
            hold_d       = fifo_out_i;
            valid_d      = 1'b1;
            rep_cnt_d    = rep_next_s;
            prev_d       = fifo_out_i;
            prev_valid_d = 1'b1;
            fail_d       = fail_q | (rep_next_s >= RepLimit);
        end else begin
            hold_d = hold_d;
        end

        if (clear_s) begin
            fail_d       = 1'b0;
            under_d      = 1'b0;
            rep_cnt_d    = 4'd0;
            prev_valid_d = 1'b0;
        end else begin
            prev_d = prev_d;
        end

        rderr_d = fifo_rderr_i | (rderr_q & ~clear_s);
    end

    // Datapath and bus response registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q      <= 1'b0;
            hold_q       <= 32'd0;
            en_q         <= 1'b0;
            irq_en_q     <= 1'b0;
            fail_q       <= 1'b0;
            rderr_q      <= 1'b0;
            under_q      <= 1'b0;
            rep_cnt_q    <= 4'd0;
            prev_q       <= 32'd0;
            prev_valid_q <= 1'b0;
            count_q      <= 32'd0;
            rdata_q      <= 32'd0;
            ack_q        <= 1'b0;
        end else begin
            valid_q      <= valid_d;
            hold_q       <= hold_d;
            en_q         <= en_d;
            irq_en_q     <= irq_en_d;
            fail_q       <= fail_d;
            rderr_q      <= rderr_d;
            under_q      <= under_d;
            rep_cnt_q    <= rep_cnt_d;
            prev_q       <= prev_d;
            prev_valid_q <= prev_valid_d;
            count_q      <= count_d;
            rdata_q      <= rdata_d;
            ack_q        <= req_i;
        end
    end

    assign rdfifo_o = rdfifo_q;
    assign rdata_o  = rdata_q;
    assign ack_o    = ack_q;

`ifdef HWRNG_READER_IRQ_EN
    logic irq_q;

    // Interrupt when a word is waiting or the health test has tripped
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= (valid_q & irq_en_q & ~fail_q) | (fail_q & irq_en_q);
        end
    end

    assign irq_o = irq_q;
`endif

endmodule
